// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_e;

  localparam int LCD_ON = 31;
  localparam int LCD_RS = 9;
  localparam int LCD_RW = 8;

  localparam logic [31:0] LCD_WINDOW_BASE = 32'h1000_4000;

  // Clear display / return home are the only commands with the long execution time.
  function automatic logic is_clear_home(input logic rs, input logic rw, input logic [7:0] data);
    return !rs && !rw && (data[7:2] == 6'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter; the zero flag marks the last cycle of a timed state.
module lcd_timer #(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count_reg <= '0;
    end else if (i_load) begin
      count_reg <= i_load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign o_zero = (count_reg == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// Turns LSU command words into timed HD44780-style bus cycles and reports busy/ready.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int T_AS   = 2,
  parameter int T_PW   = 12,
  parameter int T_H    = 1,
  parameter int T_EXEC = 2000,
  parameter int T_CLR  = 82000,
  parameter int CNT_W  = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_valid,
  input  logic [31:0] i_cmd_data,
  output logic        o_cmd_ready,
  output logic [31:0] o_status,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic        o_lcd_on,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_data_oe,
  input  logic [7:0]  i_lcd_data
);

  localparam logic [CNT_W-1:0] AS_LOAD   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_LOAD   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_LOAD    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(T_CLR - 1);

  lcd_state_e       state_reg, state_next;
  logic             accept;
  logic             on_reg, rs_reg, rw_reg;
  logic [7:0]       data_reg;
  logic [7:0]       rd_data_reg;
  logic             rd_valid_reg;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_zero;
  logic             cmd_unused;

  assign cmd_unused = ^i_cmd_data[30:10];

  assign accept = i_cmd_valid && (state_reg == IDLE);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_cmd_valid) state_next = SETUP;
      SETUP:   if (timer_zero) state_next = PULSE;
      PULSE:   if (timer_zero) state_next = HOLD;
      HOLD:    if (timer_zero) state_next = rw_reg ? IDLE : WAIT;
      WAIT:    if (timer_zero) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every state entry reloads the timer with that state's length minus one.
  always_comb begin
    timer_load       = (state_next != state_reg);
    timer_load_value = '0;
    case (state_next)
      SETUP:   timer_load_value = AS_LOAD;
      PULSE:   timer_load_value = PW_LOAD;
      HOLD:    timer_load_value = H_LOAD;
      WAIT:    timer_load_value = is_clear_home(rs_reg, rw_reg, data_reg) ? CLR_LOAD : EXEC_LOAD;
      default: timer_load_value = '0;
    endcase
  end

  lcd_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (timer_load),
    .i_load_value(timer_load_value),
    .o_zero      (timer_zero)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      on_reg   <= 1'b0;
      rs_reg   <= 1'b0;
      rw_reg   <= 1'b0;
      data_reg <= 8'd0;
    end else if (accept) begin
      on_reg   <= i_cmd_data[LCD_ON];
      rs_reg   <= i_cmd_data[LCD_RS];
      rw_reg   <= i_cmd_data[LCD_RW];
      data_reg <= i_cmd_data[7:0];
    end
  end

  // Read data is captured on the last EN-high cycle, while the panel still drives the bus.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_data_reg  <= 8'd0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= 1'b0;
      if ((state_reg == PULSE) && timer_zero && rw_reg) begin
        rd_data_reg  <= i_lcd_data;
        rd_valid_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    o_lcd_en      = 1'b0;
    o_lcd_rs      = 1'b0;
    o_lcd_rw      = 1'b0;
    o_lcd_data    = 8'd0;
    o_lcd_data_oe = 1'b0;
    case (state_reg)
      SETUP, PULSE, HOLD: begin
        o_lcd_rs      = rs_reg;
        o_lcd_rw      = rw_reg;
        o_lcd_data    = data_reg;
        o_lcd_data_oe = ~rw_reg;
        o_lcd_en      = (state_reg == PULSE);
      end
      default: ;
    endcase
  end

  assign o_cmd_ready = (state_reg == IDLE);
  assign o_status    = {~o_cmd_ready, 23'd0, rd_data_reg};
  assign o_rd_data   = rd_data_reg;
  assign o_rd_valid  = rd_valid_reg;
  assign o_lcd_on    = on_reg;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench: each issued command pushes its expected bus cycle, the negedge monitor checks it.
module tb_lcd_bus_driver;

  localparam int T_AS   = 2;
  localparam int T_PW   = 4;
  localparam int T_H    = 1;
  localparam int T_EXEC = 10;
  localparam int T_CLR  = 30;

  typedef struct {
    logic [31:0] word;
    logic        on;
    logic        rs;
    logic        rw;
    logic [7:0]  data;
    logic [7:0]  rd_byte;
    int          busy;
    int          gap;
    bit          abort;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'd0;
  logic [7:0]  lcd_in = 8'd0;
  logic        cmd_ready;
  logic [31:0] status;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_oe;
  logic [7:0]  lcd_data;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  exp_t exp_q[$];
  exp_t cur;
  bit   mon_busy = 0;
  int   cyc = 0, idle_cnt = 1000;
  int   en_cnt, en_first, en_rises, rdv_cnt;
  int   pin_err, en_err, rd_err, st_err, on_err;
  int   idle_err = 0;
  logic on_model = 1'b0;
  logic [7:0] rd_model = 8'd0;
  logic en_prev = 1'b0;

  always #5 clk = ~clk;

  lcd_bus_driver #(
    .T_AS  (T_AS),
    .T_PW  (T_PW),
    .T_H   (T_H),
    .T_EXEC(T_EXEC),
    .T_CLR (T_CLR),
    .CNT_W (17)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_cmd_valid  (cmd_valid),
    .i_cmd_data   (cmd_data),
    .o_cmd_ready  (cmd_ready),
    .o_status     (status),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_lcd_on     (lcd_on),
    .o_lcd_rs     (lcd_rs),
    .o_lcd_rw     (lcd_rw),
    .o_lcd_en     (lcd_en),
    .o_lcd_data   (lcd_data),
    .o_lcd_data_oe(lcd_oe),
    .i_lcd_data   (lcd_in)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [7:0] b, input int gap, input bit abort);
    exp_t m;
    logic clr;
    m.word    = w;
    m.on      = w[31];
    m.rs      = w[9];
    m.rw      = w[8];
    m.data    = w[7:0];
    m.rd_byte = b;
    m.gap     = gap;
    m.abort   = abort;
    clr       = !m.rs && !m.rw && (m.data[7:2] == 6'd0) && (m.data != 8'd0);
    m.busy    = T_AS + T_PW + T_H + (m.rw ? 0 : (clr ? T_CLR : T_EXEC));
    return m;
  endfunction

  // Returns just after the posedge that accepts the command currently driven.
  task automatic wait_accept();
    int n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check_val("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
  endtask

  task automatic present(input logic [31:0] w, input logic [7:0] b, input int gap, input bit abort);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    lcd_in    = b;
    exp_q.push_back(model(w, b, gap, abort));
    wait_accept();
  endtask

  task automatic release_valid();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy || !cmd_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_val("drain_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      on_model = 1'b0;
      rd_model = 8'd0;
    end
    if (!cmd_ready) begin
      if (!mon_busy) begin
        mon_busy = 1;
        cyc = 0; en_cnt = 0; en_first = 0; en_rises = 0; rdv_cnt = 0;
        pin_err = 0; en_err = 0; rd_err = 0; st_err = 0; on_err = 0;
        if (exp_q.size() == 0) begin
          check_val("unexpected_busy", 32'd1, 32'd0);
          cur = model(32'd0, 8'd0, -1, 1'b1);
        end else begin
          cur = exp_q.pop_front();
        end
        if (cur.gap >= 0) check_val("idle_gap", 32'(idle_cnt), 32'(cur.gap));
        on_model = cur.on;
      end
      cyc++;
      if (cur.rw && cyc == T_AS + T_PW + 1) rd_model = cur.rd_byte;
      if (lcd_en) begin
        en_cnt++;
        if (en_first == 0) en_first = cyc;
        if (!en_prev) en_rises++;
      end
      if (lcd_en !== (cyc > T_AS && cyc <= T_AS + T_PW)) en_err++;
      if (cyc <= T_AS + T_PW + T_H) begin
        if (lcd_rs !== cur.rs || lcd_rw !== cur.rw || lcd_data !== cur.data || lcd_oe !== ~cur.rw) pin_err++;
      end else begin
        if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0 || lcd_data !== 8'd0 || lcd_oe !== 1'b0) pin_err++;
      end
      if (rd_valid) rdv_cnt++;
      if (rd_valid !== (cur.rw && cyc == T_AS + T_PW + 1) || rd_data !== rd_model) rd_err++;
      if (status !== {1'b1, 23'd0, rd_model}) st_err++;
      if (lcd_on !== on_model) on_err++;
    end else begin
      if (mon_busy) begin
        mon_busy = 0;
        idle_cnt = 0;
        check_val("rd_pulses", 32'(rdv_cnt), cur.abort ? 32'd0 : 32'(cur.rw));
        check_val("en_shape", 32'(en_err), 32'd0);
        check_val("pin_values", 32'(pin_err), 32'd0);
        if (!cur.abort) begin
          check_val("busy_len", 32'(cyc), 32'(cur.busy));
          check_val("en_cycles", 32'(en_cnt), 32'(T_PW));
          check_val("en_start", 32'(en_first), 32'(T_AS + 1));
          check_val("en_rises", 32'(en_rises), 32'd1);
          check_val("rd_data", 32'(rd_err), 32'd0);
          check_val("status_busy", 32'(st_err), 32'd0);
          check_val("lcd_on", 32'(on_err), 32'd0);
        end
        $display("txn word=0x%08h busy=%0d en=%0d rd_pulses=%0d abort=%0d",
                 cur.word, cyc, en_cnt, rdv_cnt, cur.abort);
      end
      idle_cnt++;
      if (lcd_en !== 1'b0 || lcd_oe !== 1'b0 || lcd_rs !== 1'b0 || lcd_rw !== 1'b0 ||
          lcd_data !== 8'd0 || rd_valid !== 1'b0 || lcd_on !== on_model ||
          rd_data !== rd_model || status !== {1'b0, 23'd0, rd_model}) idle_err++;
    end
    en_prev = lcd_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    $display("lcd window base 0x%08h", lcd_pkg::LCD_WINDOW_BASE);
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_status", status, 32'd0);
    check_val("rst_pins", {23'd0, lcd_en, lcd_oe, lcd_on, lcd_rs, lcd_rw, rd_valid, 3'd0},
              32'd0);
    check_val("rst_data", {16'd0, rd_data, lcd_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Plain data write with backlight on
    present(32'h8000_0241, 8'h00, -1, 0);
    release_valid();
    drain();

    // Clear (long wait) versus a non-clear instruction
    present(32'h8000_0001, 8'h00, -1, 0);
    release_valid();
    present(32'h8000_0004, 8'h00, -1, 0);
    release_valid();
    drain();

    // Read cycle
    present(32'h8000_0100, 8'h80, -1, 0);
    release_valid();
    drain();
    check_val("status_after_read", status, 32'h0000_0080);

    // Valid held across a busy period with a changed word
    present(32'h8000_0241, 8'h00, -1, 0);
    @(negedge clk);
    cmd_data = 32'h8000_0230;
    exp_q.push_back(model(32'h8000_0230, 8'h00, 1, 0));
    wait_accept();
    release_valid();
    drain();

    // Reset asserted in the middle of the EN pulse
    present(32'h8000_0241, 8'h00, -1, 1);
    release_valid();
    repeat (3) @(negedge clk);
    check_val("en_before_reset", 32'(lcd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("reset_async_pins", {29'd0, lcd_en, lcd_oe, lcd_on}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("ready_after_reset", 32'(cmd_ready), 32'd1);
    drain();

    // Backlight-off command after a backlight-on command
    present(32'h8000_0241, 8'h00, -1, 0);
    release_valid();
    drain();
    check_val("on_before_second", 32'(lcd_on), 32'd1);
    present(32'h0000_0241, 8'h00, -1, 0);
    #1;
    check_val("on_after_second", 32'(lcd_on), 32'd0);
    release_valid();
    drain();

    check_val("idle_cycles", 32'(idle_err), 32'd0);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
